// File: rtl/estacionamiento_top.sv
// ---------------------------------------------------------------------------
// estacionamiento_top
//
// Parking-lot occupancy counter fed by two photo-sensors along the lane:
// a (outer) and b (inner), 1 = beam blocked. An entering car walks the sensor
// pair through ab 00->10->11->01->00 and a leaving car walks 00->01->11->10->00.
// A direction-decoding FSM turns completed walks into entry/exit events, and a
// saturating counter tracks how many cars are parked.
//
// Build option:
//   ESTACIONAMIENTO_SYNC_EN defined   -> a/b pass through a two-flop
//                                        synchronizer (raw input to count
//                                        change: 3 rising edges).
//   ESTACIONAMIENTO_SYNC_EN undefined -> a single register stage (2 edges).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   a, b        in   outer / inner sensor, asynchronous to clk
//   count       out  current occupancy (WIDTH bits)
//   full        out  count == CAPACITY
//   empty       out  count == 0
//   entry_pulse out  one-cycle pulse per accepted entry
//   exit_pulse  out  one-cycle pulse per accepted exit
//   seq_error   out  one-cycle pulse on an illegal sensor transition
//   state_dbg   out  current FSM state encoding (debug visibility)
//
// Handshake: there is none; sensor inputs are level signals sampled every
// clock, and all event outputs are single-cycle pulses with no back-pressure.
// ---------------------------------------------------------------------------
module estacionamiento_top #(
    parameter int WIDTH    = 3,
    parameter int CAPACITY = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             seq_error,
    output logic [2:0]       state_dbg
);

    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IN1  = 3'd1,
        S_IN2  = 3'd2,
        S_IN3  = 3'd3,
        S_OUT1 = 3'd4,
        S_OUT2 = 3'd5,
        S_OUT3 = 3'd6,
        S_WAIT = 3'd7
    } state_e;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic a_s_q, a_s_d;
    logic b_s_q, b_s_d;

`ifdef ESTACIONAMIENTO_SYNC_EN
    logic a_m_q, a_m_d;
    logic b_m_q, b_m_d;

    always_comb begin
        a_m_d = a;
        b_m_d = b;
        a_s_d = a_m_q;
        b_s_d = b_m_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_m_q <= 1'b0;
            b_m_q <= 1'b0;
        end else begin
            a_m_q <= a_m_d;
            b_m_q <= b_m_d;
        end
    end
`else
    always_comb begin
        a_s_d = a;
        b_s_d = b;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_s_q <= 1'b0;
            b_s_q <= 1'b0;
        end else begin
            a_s_q <= a_s_d;
            b_s_q <= b_s_d;
        end
    end

    // ------------------------------------------------------------------
    // Direction-decoding FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic             entry_evt, exit_evt;
    logic             seq_error_q, seq_error_d;
    logic [1:0]       ab;

    always_comb begin
        ab          = {a_s_q, b_s_q};
        state_d     = state_q;
        entry_evt   = 1'b0;
        exit_evt    = 1'b0;
        seq_error_d = 1'b0;
        // An input equal to the state's own code falls through to "stay".
        case (state_q)
            S_IDLE: begin
                case (ab)
                    2'b10:   state_d = S_IN1;
                    2'b01:   state_d = S_OUT1;
                    2'b11:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_IN1: begin
                case (ab)
                    2'b11:   state_d = S_IN2;
                    2'b00:   state_d = S_IDLE;
                    2'b01:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_IN2: begin
                case (ab)
                    2'b01:   state_d = S_IN3;
                    2'b10:   state_d = S_IN1;   // car backing out
                    2'b00:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_IN3: begin
                case (ab)
                    2'b00:   begin state_d = S_IDLE; entry_evt = 1'b1; end
                    2'b11:   state_d = S_IN2;
                    2'b10:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT1: begin
                case (ab)
                    2'b11:   state_d = S_OUT2;
                    2'b00:   state_d = S_IDLE;
                    2'b10:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT2: begin
                case (ab)
                    2'b10:   state_d = S_OUT3;
                    2'b01:   state_d = S_OUT1;
                    2'b00:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_OUT3: begin
                case (ab)
                    2'b00:   begin state_d = S_IDLE; exit_evt = 1'b1; end
                    2'b11:   state_d = S_OUT2;
                    2'b01:   begin state_d = S_WAIT; seq_error_d = 1'b1; end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (ab == 2'b00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating occupancy counter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_q, count_d;
    logic             entry_pulse_q, entry_pulse_d;
    logic             exit_pulse_q, exit_pulse_d;

    always_comb begin
        count_d       = count_q;
        entry_pulse_d = 1'b0;
        exit_pulse_d  = 1'b0;
        // Events arriving at a limit are dropped silently: no wrap, no pulse.
        if (entry_evt && (count_q < CAP)) begin
            count_d       = count_q + 1'b1;
            entry_pulse_d = 1'b1;
        end else if (exit_evt && (count_q != '0)) begin
            count_d      = count_q - 1'b1;
            exit_pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            entry_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            entry_pulse_q <= entry_pulse_d;
            exit_pulse_q  <= exit_pulse_d;
            seq_error_q   <= seq_error_d;
        end
    end

    assign count       = count_q;
    assign full        = (count_q == CAP);
    assign empty       = (count_q == '0);
    assign entry_pulse = entry_pulse_q;
    assign exit_pulse  = exit_pulse_q;
    assign seq_error   = seq_error_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_estacionamiento_top.sv
// ---------------------------------------------------------------------------
// tb_estacionamiento_top
//
// Directed bench for estacionamiento_top. Each sensor pattern is held for
// three clocks, which covers the sampling latency with or without the
// two-flop synchronizer. Pulses are tallied by a small monitor so the
// directed sequence can check how many of each appeared.
// ---------------------------------------------------------------------------
module tb_estacionamiento_top;

    localparam int WIDTH    = 3;
    localparam int CAPACITY = 7;

    localparam int ST_IDLE = 0;
    localparam int ST_WAIT = 7;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic [WIDTH-1:0] count;
    logic             full, empty, entry_pulse, exit_pulse, seq_error;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    estacionamiento_top #(.WIDTH(WIDTH), .CAPACITY(CAPACITY)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .seq_error   (seq_error),
        .state_dbg   (state_dbg)
    );

    // ---------------- pulse monitor ----------------
    int n_entry = 0;
    int n_exit  = 0;
    int n_err   = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (entry_pulse) n_entry++;
            if (exit_pulse)  n_exit++;
            if (seq_error)   n_err++;
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] ab);
        @(negedge clk);
        {a, b} = ab;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_entry();
        drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
    endtask

    task automatic do_exit();
        drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
    endtask

    // ---------------- directed sequence ----------------
    int e0, x0, r0;

    initial begin
        // Reset held 5 cycles with sensors clear.
        reset = 1'b0; a = 1'b0; b = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_pulses", int'({entry_pulse, exit_pulse, seq_error}), 0);
        chk("rst_state", int'(state_dbg), ST_IDLE);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single entry.
        do_entry();
        chk("entry1_count", int'(count), 1);
        chk("entry1_pulses", n_entry, 1);
        chk("entry1_empty", int'(empty), 0);
        chk("entry1_state", int'(state_dbg), ST_IDLE);

        // Back to zero with one exit.
        do_exit();
        chk("exit1_count", int'(count), 0);
        chk("exit1_pulses", n_exit, 1);
        chk("exit1_empty", int'(empty), 1);

        // Saturation: seven entries fill, the eighth is dropped.
        e0 = n_entry;
        for (int i = 0; i < 7; i++) do_entry();
        chk("sat7_count", int'(count), 7);
        chk("sat7_full", int'(full), 1);
        chk("sat7_pulses", n_entry - e0, 7);
        do_entry();
        chk("sat8_count", int'(count), 7);
        chk("sat8_pulses", n_entry - e0, 7);
        chk("sat8_full", int'(full), 1);

        // Exit from full.
        x0 = n_exit;
        do_exit();
        chk("exit7_count", int'(count), 6);
        chk("exit7_pulses", n_exit - x0, 1);
        chk("exit7_full", int'(full), 0);

        // Drain, then an exit at zero is dropped.
        for (int i = 0; i < 6; i++) do_exit();
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_pulses", n_exit - x0, 7);
        do_exit();
        chk("exit0_count", int'(count), 0);
        chk("exit0_pulses", n_exit - x0, 7);

        // Aborted / reversed entry from count=1.
        do_entry();
        e0 = n_entry; x0 = n_exit; r0 = n_err;
        drive(2'b10); drive(2'b11); drive(2'b10); drive(2'b00);
        chk("abort_count", int'(count), 1);
        chk("abort_pulses", (n_entry - e0) + (n_exit - x0) + (n_err - r0), 0);
        chk("abort_state", int'(state_dbg), ST_IDLE);

        // Illegal jump from IDLE.
        drive(2'b11);
        chk("illegal_err", n_err - r0, 1);
        chk("illegal_state", int'(state_dbg), ST_WAIT);
        drive(2'b01); drive(2'b00);
        chk("illegal_count", int'(count), 1);
        chk("illegal_err_once", n_err - r0, 1);
        chk("illegal_idle", int'(state_dbg), ST_IDLE);
        chk("illegal_no_evt", (n_entry - e0) + (n_exit - x0), 0);
        do_entry();
        chk("after_illegal_count", int'(count), 2);
        chk("after_illegal_pulse", n_entry - e0, 1);

        // Reset mid-sequence aborts and clears the count.
        drive(2'b10); drive(2'b11);
        reset = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_state", int'(state_dbg), ST_IDLE);
        a = 1'b0; b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_count", int'(count), 0);
        chk("postrst_empty", int'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/estacionamiento_top.md
Name: estacionamiento_top

Overview:
Parking-lot occupancy counter driven by two photo-sensors, a (outer) and b (inner), placed along the lane.
- A vehicle entering produces the Gray sequence ab 00→10→11→01→00; a vehicle leaving produces 00→01→11→10→00.
- A direction-decoding FSM turns completed sequences into entry/exit events.
- A saturating counter tracks the number of cars parked. Sits between the sensor pins and the display/gate logic.

Parameters:
- WIDTH, 3, bit width of count.
- CAPACITY, 7, maximum occupancy; must be ≤ 2^WIDTH−1.

Ports:
- clk input 1: system clock, rising-edge.
- reset input 1: asynchronous, active-low reset.
- a input 1: outer sensor, 1 = beam blocked; asynchronous to clk.
- b input 1: inner sensor, 1 = beam blocked; asynchronous to clk.
- count output WIDTH: current occupancy.
- full output 1: count == CAPACITY.
- empty output 1: count == 0.
- entry_pulse output 1: one-cycle pulse on each accepted entry.
- exit_pulse output 1: one-cycle pulse on each accepted exit.
- seq_error output 1: one-cycle pulse on an illegal sensor transition.

Behaviour:
- Reset (reset=0, async) state: FSM=IDLE, count=0, empty=1, full=0, all pulses 0, sampling flops cleared to 0.
- Input sampling: a,b registered into a_s,b_s; the FSM uses only a_s,b_s. Stage depth depends on SYNC_EN.
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT. Evaluated every clk edge on {a_s,b_s}. Input equal to the state's current code means stay.
- IDLE (00): 10→IN1; 01→OUT1; 11→WAIT with seq_error.
- IN1 (10): 11→IN2; 00→IDLE, no event; 01→WAIT with seq_error.
- IN2 (11): 01→IN3; 10→IN1 (car backing out); 00→WAIT with seq_error.
- IN3 (01): 00→IDLE with entry event; 11→IN2; 10→WAIT with seq_error.
- OUT1/OUT2/OUT3: mirror of IN1/IN2/IN3 with a and b swapped. OUT3 (10)→00 gives the exit event.
- WAIT: stays until {a_s,b_s}==00, then goes to IDLE with no event.
- Entry event: if count<CAPACITY, count+1 and entry_pulse=1. Otherwise count holds, no pulse (saturate; no wrap).
- Exit event: if count>0, count−1 and exit_pulse=1. Otherwise count holds, no pulse.
- Entry and exit events are mutually exclusive by construction.
- Latency: count/pulses update on the clk edge after a_s,b_s first shows 00 in IN3/OUT3.
- full and empty are combinational decodes of registered count.
- reset asserted mid-sequence aborts the sequence; count clears to 0 immediately.

Optional Feature:
- Macro: ESTACIONAMIENTO_SYNC_EN.
- Defined: a and b pass through a two-flop synchronizer. Raw input to count change is 3 rising edges.
- Undefined: a single register stage. Raw input to count change is 2 rising edges.
- FSM and counter behaviour are otherwise identical.

Test Plan:
- Reset: hold reset=0 for 5 cycles with a=b=0 → count=0, empty=1, full=0, no pulses. Release reset.
- Single entry: drive ab 10,11,01,00, each held ≥1 cycle → count=1, exactly one entry_pulse, empty=0.
- Saturation: 8 consecutive entry sequences from count=0 → count reaches 7 after the 7th with full=1. 8th gives no entry_pulse; count stays 7.
- Exit: from count=7 drive 01,11,10,00 → count=6, one exit_pulse, full=0. An exit sequence at count=0 → count stays 0, no exit_pulse.
- Aborted/reversed: drive 10,11,10,00 → count unchanged, no pulses, FSM back to IDLE.
- Illegal jump: from IDLE drive 11 → seq_error pulse. Follow with 01,00 → no count change. Then a legal entry → count+1.
